// File: rtl/matrix_slot_scanner_pkg.sv
// Shared types, header field positions and the slot-match rule for the
// matrix slot scanner.
package matrix_slot_scanner_pkg;

  typedef enum logic [1:0] {
    MATCH_EXACT     = 2'd0,
    MATCH_TRANSPOSE = 2'd1,
    MATCH_ANY       = 2'd2
  } match_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CMP    = 3'd3,
    ST_FINISH = 3'd4,
    ST_PICK   = 3'd5
  } scan_state_t;

  localparam int HDR_ROWS_MSB = 31;
  localparam int HDR_ROWS_LSB = 24;
  localparam int HDR_COLS_MSB = 23;
  localparam int HDR_COLS_LSB = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // An empty slot (zero rows or zero cols) never matches, whatever the mode.
  function automatic logic header_matches(input match_mode_t mode,
                                          input logic [7:0]  rows,
                                          input logic [7:0]  cols,
                                          input logic [7:0]  want_rows,
                                          input logic [7:0]  want_cols);
    logic empty;
    logic hit;
    empty = (rows == 8'd0) || (cols == 8'd0);
    case (mode)
      MATCH_EXACT:     hit = (rows == want_rows) && (cols == want_cols);
      MATCH_TRANSPOSE: hit = (rows == want_cols) && (cols == want_rows);
      MATCH_ANY:       hit = 1'b1;
      default:         hit = 1'b0;
    endcase
    return !empty && hit;
  endfunction

endpackage

// File: rtl/matrix_slot_scanner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), stepping every cycle.
module lfsr16
  import matrix_slot_scanner_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic        feedback_d;

  always_comb begin
    feedback_d = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], feedback_d};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/matrix_slot_scanner.sv
// Scans the header word of every matrix slot in BRAM, builds a mask of slots
// matching the requested shape, and hands out random matching slots on request.
module matrix_slot_scanner
  import matrix_slot_scanner_pkg::*;
#(
  parameter int NUM_SLOTS    = 8,
  parameter int BLOCK_SIZE   = 1152,
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1,
  parameter int SLOT_W       = $clog2(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            match_rows,
  input  logic [7:0]            match_cols,
  input  match_mode_t           match_mode,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [31:0]           bram_data,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_SLOTS-1:0]  valid_mask,
  output logic [SLOT_W:0]       match_count,
  input  logic                  pick_req,
  output logic                  pick_valid,
  output logic [SLOT_W-1:0]     pick_id,
  output logic                  pick_err
);

  scan_state_t           state_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [SLOT_W-1:0]     cursor_q;
  logic [1:0]            wait_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  match_mode_t           mode_q;
  logic [NUM_SLOTS-1:0]  valid_mask_q;
  logic [SLOT_W:0]       match_count_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pick_valid_q;
  logic                  pick_err_q;
  logic [SLOT_W-1:0]     pick_id_q;

  logic [15:0]           lfsr_value;
  logic [7:0]            hdr_rows_d;
  logic [7:0]            hdr_cols_d;
  logic                  hit_d;
  logic [NUM_SLOTS-1:0]  mask_d;
  logic [SLOT_W:0]       count_d;
  logic [SLOT_W-1:0]     slot_next_d;
  logic [ADDR_WIDTH-1:0] slot_addr_d;
  logic [SLOT_W-1:0]     cursor_start_d;
  logic [SLOT_W-1:0]     cursor_next_d;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .value(lfsr_value)
  );

  // Header decode, mask/count update for the slot in CMP, and cursor stepping.
  always_comb begin
    hdr_rows_d = bram_data[HDR_ROWS_MSB:HDR_ROWS_LSB];
    hdr_cols_d = bram_data[HDR_COLS_MSB:HDR_COLS_LSB];
    hit_d      = header_matches(mode_q, hdr_rows_d, hdr_cols_d, rows_q, cols_q);
    mask_d         = valid_mask_q;
    mask_d[slot_q] = hit_d;
    count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_d = count_d + {{SLOT_W{1'b0}}, mask_d[i]};
    end
    slot_next_d    = slot_q + SLOT_W'(1);
    slot_addr_d    = ADDR_WIDTH'(32'(slot_next_d) * BLOCK_SIZE);
    cursor_start_d = SLOT_W'(lfsr_value % 16'(NUM_SLOTS));
    if (cursor_q == SLOT_W'(NUM_SLOTS - 1)) begin
      cursor_next_d = '0;
    end else begin
      cursor_next_d = cursor_q + SLOT_W'(1);
    end
  end

  // Scan/pick controller; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      cursor_q      <= '0;
      wait_q        <= 2'd0;
      rows_q        <= 8'd0;
      cols_q        <= 8'd0;
      mode_q        <= MATCH_EXACT;
      valid_mask_q  <= '0;
      match_count_q <= '0;
      bram_addr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pick_valid_q  <= 1'b0;
      pick_err_q    <= 1'b0;
      pick_id_q     <= '0;
    end else begin
      done_q       <= 1'b0;
      pick_valid_q <= 1'b0;
      pick_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // start has priority; a simultaneous pick_req is dropped
          if (start) begin
            rows_q        <= match_rows;
            cols_q        <= match_cols;
            mode_q        <= match_mode;
            valid_mask_q  <= '0;
            match_count_q <= '0;
            slot_q        <= '0;
            bram_addr_q   <= '0;
            busy_q        <= 1'b1;
            state_q       <= ST_ADDR;
          end else if (pick_req) begin
            if (valid_mask_q == '0) begin
              pick_err_q <= 1'b1;
            end else begin
              cursor_q <= cursor_start_d;
              busy_q   <= 1'b1;
              state_q  <= ST_PICK;
            end
          end
        end
        ST_ADDR: begin
          if (READ_LATENCY > 1) begin
            wait_q  <= 2'(READ_LATENCY - 2);
            state_q <= ST_WAIT;
          end else begin
            bram_addr_q <= '0;
            state_q     <= ST_CMP;
          end
        end
        ST_WAIT: begin
          if (wait_q == 2'd0) begin
            bram_addr_q <= '0;
            state_q     <= ST_CMP;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        ST_CMP: begin
          valid_mask_q <= mask_d;
          if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
            match_count_q <= count_d;
            done_q        <= 1'b1;
            state_q       <= ST_FINISH;
          end else begin
            slot_q      <= slot_next_d;
            bram_addr_q <= slot_addr_d;
            state_q     <= ST_ADDR;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_PICK: begin
          if (valid_mask_q[cursor_q]) begin
            pick_id_q    <= cursor_q;
            pick_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            cursor_q <= cursor_next_d;
          end
        end
        default: begin
          bram_addr_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bram_addr   = bram_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign valid_mask  = valid_mask_q;
  assign match_count = match_count_q;
  assign pick_valid  = pick_valid_q;
  assign pick_id     = pick_id_q;
  assign pick_err    = pick_err_q;

endmodule

// File: tb/tb_matrix_slot_scanner.sv
// Randomized scoreboard bench for matrix_slot_scanner with a shape-rule
// reference model and an independent LFSR model for pick prediction.
module tb_matrix_slot_scanner;
  import matrix_slot_scanner_pkg::*;

  localparam int N  = 8;
  localparam int BS = 1152;
  localparam int AW = 14;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    match_rows = 8'd0;
  logic [7:0]    match_cols = 8'd0;
  match_mode_t   match_mode = MATCH_EXACT;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_data = 32'd0;
  logic          busy, done, pick_valid, pick_err, pick_req = 1'b0;
  logic [N-1:0]  valid_mask;
  logic [SW:0]   match_count;
  logic [SW-1:0] pick_id;

  matrix_slot_scanner #(
    .NUM_SLOTS(N), .BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .match_rows(match_rows),
    .match_cols(match_cols), .match_mode(match_mode), .bram_addr(bram_addr),
    .bram_data(bram_data), .busy(busy), .done(done), .valid_mask(valid_mask),
    .match_count(match_count), .pick_req(pick_req), .pick_valid(pick_valid),
    .pick_id(pick_id), .pick_err(pick_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] hdr_r [N];
  logic [7:0] hdr_c [N];
  logic [15:0] ref_lfsr;
  logic [N-1:0] cur_mask = '0;
  logic [N-1:0] seen_ids = '0;

  typedef struct { logic [N-1:0] mask; int cnt; int at; } scan_exp_t;
  typedef struct { int id; int issued; } pick_exp_t;
  scan_exp_t scan_q[$];
  pick_exp_t pick_q[$];
  int        err_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read BRAM: header word at k*BS, distinctive junk elsewhere.
  function automatic logic [31:0] mem_read(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    if ((ai % BS) == 0 && (ai / BS) < N) return {hdr_r[ai/BS], hdr_c[ai/BS], 16'h5A5A};
    return {16'hFFFF, 2'b00, a};
  endfunction

  always @(posedge clk) bram_data <= mem_read(bram_addr);

  // Polynomial x^16+x^14+x^13+x^11 expressed as a tap mask.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 16'hACE1;
    else        ref_lfsr <= {ref_lfsr[14:0], ^(ref_lfsr & 16'hB400)};
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [N-1:0] exp_mask(input match_mode_t m, input int mr, input int mc);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (hdr_r[k] != 8'd0 && hdr_c[k] != 8'd0) begin
        if (m == MATCH_ANY) r[k] = 1'b1;
        else if (m == MATCH_EXACT) r[k] = (hdr_r[k] == mr[7:0]) && (hdr_c[k] == mc[7:0]);
        else r[k] = (hdr_r[k] == mc[7:0]) && (hdr_c[k] == mr[7:0]);
      end
    end
    return r;
  endfunction

  function automatic int exp_pick(input logic [N-1:0] m, input int first);
    for (int i = 0; i < N; i++) if (m[(first + i) % N]) return (first + i) % N;
    return -1;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (scan_q.size() == 0) flag("unexpected_done");
        else begin
          scan_exp_t e;
          e = scan_q.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("valid_mask", int'(valid_mask), int'(e.mask));
          chk("match_count", int'(match_count), e.cnt);
        end
      end
      if (pick_valid) begin
        if (pick_q.size() == 0) flag("unexpected_pick_valid");
        else begin
          pick_exp_t p;
          p = pick_q.pop_front();
          chk("pick_id", int'(pick_id), p.id);
          seen_ids[pick_id] = 1'b1;
          if ((cyc - p.issued) > N + 1 || (cyc - p.issued) < 2) chk("pick_latency", cyc - p.issued, N);
        end
      end
      if (pick_err) begin
        if (err_q.size() == 0) flag("unexpected_pick_err");
        else chk("pick_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || scan_q.size() != 0 || pick_q.size() != 0 || err_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      flag("idle_timeout");
      scan_q.delete(); pick_q.delete(); err_q.delete();
    end
  endtask

  task automatic issue_scan(input match_mode_t m, input int r, input int c, input bit with_pick);
    scan_exp_t e;
    wait_idle();
    e.mask = exp_mask(m, r, c);
    e.cnt  = $countones(e.mask);
    e.at   = cyc + 17;
    scan_q.push_back(e);
    cur_mask   = e.mask;
    match_mode = m; match_rows = r[7:0]; match_cols = c[7:0];
    start = 1'b1; pick_req = with_pick;
    @(negedge clk);
    start = 1'b0; pick_req = 1'b0;
  endtask

  task automatic issue_pick();
    pick_exp_t p;
    wait_idle();
    chk("mask_hold", int'(valid_mask), int'(cur_mask));
    if (cur_mask == '0) err_q.push_back(cyc + 1);
    else begin
      p.id = exp_pick(cur_mask, int'(ref_lfsr % 16'(N)));
      p.issued = cyc;
      pick_q.push_back(p);
    end
    pick_req = 1'b1;
    @(negedge clk);
    pick_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_mask"}, int'(valid_mask), 0);
    chk({tag, "_count"}, int'(match_count), 0);
    chk({tag, "_pick_id"}, int'(pick_id), 0);
    chk({tag, "_pick_valid"}, int'(pick_valid), 0);
    chk({tag, "_pick_err"}, int'(pick_err), 0);
    chk({tag, "_addr"}, int'(bram_addr), 0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin hdr_r[k] = 8'd0; hdr_c[k] = 8'd0; end
    hdr_r[0] = 8'd3; hdr_c[0] = 8'd3;
    hdr_r[1] = 8'd3; hdr_c[1] = 8'd3;
    hdr_r[2] = 8'd4; hdr_c[2] = 8'd4;
    hdr_r[3] = 8'd3; hdr_c[3] = 8'd4;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // EXACT 3x3, with a second start and a pick_req mid-scan that must be ignored
    issue_scan(MATCH_EXACT, 3, 3, 1'b0);
    repeat (4) @(negedge clk);
    match_rows = 8'd4; match_cols = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pick_req = 1'b1;
    @(negedge clk);
    pick_req = 1'b0;

    for (int i = 0; i < 50; i++) issue_pick();
    wait_idle();
    chk("both_ids_seen", int'(seen_ids), 3);

    issue_scan(MATCH_EXACT, 5, 5, 1'b0);
    issue_pick();
    issue_scan(MATCH_TRANSPOSE, 4, 3, 1'b0);
    issue_scan(MATCH_ANY, 0, 0, 1'b0);
    issue_pick();
    issue_scan(MATCH_EXACT, 4, 4, 1'b1);
    issue_pick();

    // Reset five cycles into a scan: aborted, no done afterwards
    issue_scan(MATCH_EXACT, 3, 3, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    scan_q.delete();
    cur_mask = '0;
    @(negedge clk);
    chk_all_zero("midscan_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue_scan(MATCH_EXACT, 4, 4, 1'b0);
    wait_idle();
    chk("post_reset_mask", int'(valid_mask), 4);

    for (int it = 0; it < 25; it++) begin
      int ref_slot;
      match_mode_t m;
      wait_idle();
      for (int k = 0; k < N; k++) begin
        hdr_r[k] = 8'($urandom_range(0, 4));
        hdr_c[k] = 8'($urandom_range(0, 4));
      end
      ref_slot = $urandom_range(0, N - 1);
      m = match_mode_t'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) issue_scan(m, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
      else issue_scan(m, int'(hdr_r[ref_slot]), int'(hdr_c[ref_slot]), 1'b0);
      for (int p = 0; p < 3; p++) issue_pick();
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
